// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : bus-mapped 8N1 serial transmitter with a write FIFO.
// Optional CTRL register and interrupt are built when UART_TX_IRQ_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CLK_DIV = 27,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       irq
);

  localparam int          c_DEPTH  = 1 << FIFO_AW;
  localparam logic [15:0] c_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_baud, w_baud_nxt;
  logic [2:0]       r_bitcnt, w_bitcnt_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_tx, w_tx_nxt;
  logic             w_pop;

  logic [7:0]       r_mem [c_DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic             r_ovf;
  logic [7:0]       r_dout;
  logic [7:0]       w_rd_val;
  logic [7:0]       w_head;
  logic             w_empty, w_full, w_busy, w_tick;
  logic             w_wr, w_rd, w_wr_data, w_push, w_wr_status, w_wr_ctrl;
  logic             w_irq_en;

  assign w_wr        = cs && we;
  assign w_rd        = cs && !we;
  assign w_wr_data   = w_wr && (addr == 2'd0);
  assign w_wr_status = w_wr && (addr == 2'd1);
  assign w_wr_ctrl   = w_wr && (addr == 2'd2);

  // Full is judged on the pre-edge pointers, so a same-cycle pop never rescues a push.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_push  = w_wr_data && !w_full;
  assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];

  assign w_wptr_nxt = r_wptr + (FIFO_AW+1)'(w_push);
  assign w_rptr_nxt = r_rptr + (FIFO_AW+1)'(w_pop);

  assign w_busy = (r_state != S_IDLE);
  assign w_tick = (r_baud == 16'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= data_in;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = c_RELOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt  = S_DATA;
          w_tx_nxt     = r_shift[0];
          w_bitcnt_nxt = 3'd0;
          w_baud_nxt   = c_RELOAD;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_nxt = c_RELOAD;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_tx_nxt     = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_baud_nxt  = c_RELOAD;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= 16'd0;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_tx     <= 1'b1;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ovf    <= 1'b0;
      r_dout   <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      if (w_wr_status) begin
        r_ovf <= 1'b0;
      end else if (w_wr_data && w_full) begin
        r_ovf <= 1'b1;
      end
      if (w_rd) begin
        r_dout <= w_rd_val;
      end
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_ctrl, w_ctrl_nxt, r_irq;

  assign w_ctrl_nxt = w_wr_ctrl ? data_in[0] : r_ctrl;
  assign w_irq_en   = r_ctrl;

  // Interrupt tracks the post-edge state so it is exact on the cycle it changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      r_irq  <= w_ctrl_nxt && (w_wptr_nxt == w_rptr_nxt) && (w_state_nxt == S_IDLE);
    end
  end

  assign irq = r_irq;
`else
  logic w_ctrl_unused;

  assign w_ctrl_unused = w_wr_ctrl;
  assign w_irq_en      = 1'b0;
  assign irq           = 1'b0;
`endif

  always_comb begin
    w_rd_val = 8'h00;
    case (addr)
      2'd1:    w_rd_val = {4'b0000, r_ovf, w_empty, w_full, w_busy};
      2'd2:    w_rd_val = {7'b0000000, w_irq_en};
      default: w_rd_val = 8'h00;
    endcase
  end

  assign data_out = r_dout;
  assign tx       = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : scoreboard bench for uart_tx (CLK_DIV=4, 4-entry FIFO).
// Revision : 1.0
// ============================================================================
module tb_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;

  logic       clk;
  logic       reset;
  logic       cs;
  logic [1:0] addr;
  logic       we;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       tx;
  logic       irq;

  uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .addr     (addr),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_frames = 0;
  bit         mon_busy = 0;
  logic [7:0] q_exp[$];
  int         q_starts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = data_out;
  endtask

  task automatic send(input logic [7:0] d);
    q_exp.push_back(d);
    bus_write(2'd0, d);
  endtask

  // Reads STATUS every cycle until (STATUS & mask) == want; k=1 is the read at the next edge.
  task automatic poll_status(input logic [7:0] mask, input logic [7:0] want, input int budget,
                             output int k, output logic [7:0] first);
    cs = 1'b1; we = 1'b0; addr = 2'd1;
    k = 0;
    first = 8'h00;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) first = data_out;
    end while (((data_out & mask) != want) && (k < budget));
    cs = 1'b0;
    if ((data_out & mask) != want) check("poll_timeout", data_out & mask, want);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q_exp.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", q_exp.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Serial monitor: every bit must hold for exactly CLK_DIV samples.
  initial begin : mon
    logic [9:0] bits;
    bit         stable;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset && tx == 1'b0) begin
        mon_busy = 1;
        q_starts.push_back(cyc);
        bits = '0;
        stable = 1;
        aborted = 0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int s = 0; s < CLK_DIV && !aborted; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!reset) aborted = 1;
            else if (s == 0) bits[b] = tx;
            else if (tx != bits[b]) stable = 0;
          end
        end
        if (!aborted) begin
          n_frames++;
          check("frame_stable", stable, 1);
          check("stop_bit", bits[9], 1);
          if (q_exp.size() == 0) check("frame_without_expect", q_exp.size(), 1);
          else check("rx_byte", bits[8:1], q_exp.pop_front());
        end
        mon_busy = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] d;
    logic [7:0] first;
    int         k;
    int         ones;
    int         nf;

    reset = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_dout", data_out, 8'h00);
    check("rst_irq", irq, 0);
    reset = 1'b1;
    bus_read(2'd1, d); check("rst_status", d, 8'h04);
    bus_read(2'd0, d); check("data_reads_zero", d, 8'h00);
    bus_read(2'd3, d); check("off3_reads_zero", d, 8'h00);
    check("irq_idle_disabled", irq, 0);

    // Single byte with exact busy timing.
    q_starts.delete();
    send(8'hA5);
    poll_status(8'h01, 8'h01, 100, k, first);
    check("a5_first_status", first, 8'h00);
    check("busy_rise", k, 2);
    poll_status(8'h01, 8'h00, 200, k, first);
    check("busy_fall", k, 40);
    check("a5_idle_status", data_out, 8'h04);
    wait_drain(100);

    // Back-to-back frames.
    q_starts.delete();
    send(8'h3C);
    send(8'hFF);
    send(8'h81);
    wait_drain(500);
    check("b2b_frames", q_starts.size(), 3);
    if (q_starts.size() >= 3) begin
      check("b2b_gap1", q_starts[1] - q_starts[0], 10 * CLK_DIV);
      check("b2b_gap2", q_starts[2] - q_starts[1], 10 * CLK_DIV);
    end
    bus_read(2'd1, d); check("b2b_end_status", d, 8'h04);

    // Overflow: fill, let one slot open, accept one extra, drop the next.
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    bus_read(2'd1, d); check("full_status", d, 8'h03);
    poll_status(8'h02, 8'h00, 200, k, first);
    send(8'h66);
    bus_write(2'd0, 8'h77);
    bus_read(2'd1, d); check("ovf_status", d, 8'h0B);
    bus_write(2'd1, 8'h00);
    bus_read(2'd1, d); check("ovf_cleared", d, 8'h03);
    wait_drain(800);
    bus_read(2'd1, d); check("ovf_end_status", d, 8'h04);

    // Interrupt.
`ifdef UART_TX_IRQ_EN
    bus_write(2'd2, 8'h01);
    check("irq_armed", irq, 1);
    bus_read(2'd2, d); check("ctrl_read", d, 8'h01);
    send(8'h5A);
    check("irq_low_in_frame", irq, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (irq == 1'b0 && k < 200);
    check("irq_rise", k, 41);
`else
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, d); check("ctrl_read", d, 8'h00);
    send(8'h5A);
    ones = 0;
    repeat (50) begin
      @(negedge clk);
      if (irq) ones++;
    end
    check("irq_tied", ones, 0);
`endif
    wait_drain(200);

    // Reset mid-DATA bit: tx must rise without a clock edge.
    send(8'h00);
    repeat (7) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    #1 reset = 1'b0;
    #1 check("async_tx", tx, 1);
    q_exp.delete();
    nf = n_frames;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus_read(2'd1, d); check("post_rst_status", d, 8'h04);
    bus_read(2'd2, d); check("post_rst_ctrl", d, 8'h00);
    repeat (60) @(negedge clk);
    check("no_resume", n_frames, nf);
    check("idle_tx", tx, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Memory-mapped serial transmitter peripheral on the 65C02 bus, clocked by the CPU clock alongside RAM, boot ROM and the I/O port register. The CPU writes bytes into a small FIFO; an 8N1 serialiser drains the FIFO onto `tx` at a fixed bit period. Reads use the same one-cycle registered latency as the synchronous ROM and RAM, so the top-level read mux selects `data_out` with the registered I/O address.

## Interface
- `CLK_DIV`, 27: `clk` cycles per serial bit; legal range 2..65535.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW entries.
- `clk` in 1: CPU clock; all state changes on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (asserted when 0).
- `cs` in 1: chip select, decoded by top level from the CPU address.
- `addr` in 2: register offset.
- `we` in 1: CPU write strobe (the CPU's WE).
- `data_in` in 8: CPU write data.
- `data_out` out 8: registered read data.
- `tx` out 1: serial output, idle high.
- `irq` out 1: level interrupt, active-high (see Configuration).

## Operation
- Offset 0 DATA: write pushes `data_in` into the FIFO; read returns 0x00.
- Offset 1 STATUS (read): bit0 busy (serialiser not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits7:4 = 0. Any write clears overflow.
- Offset 2 CTRL: bit0 irq_en, read/write; other bits read 0.
- Offset 3: reads 0x00, writes ignored.
- FIFO: circular, FIFO_AW-bit read/write pointers plus one extra bit to distinguish full/empty; pointers wrap modulo depth.
- Push when full: byte dropped, overflow set; a pop in the same cycle does not rescue it.
- Serialiser FSM: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE or START.
  - IDLE: if FIFO non-empty, pop into shift register, enter START.
  - Each of START, each DATA bit, STOP lasts exactly CLK_DIV cycles, timed by a baud counter reloaded at each bit boundary.
  - End of STOP: if FIFO non-empty, pop and enter START directly (no idle gap); else IDLE.
- `tx` driven from a register: 1 in IDLE/STOP, 0 in START, shift bit in DATA.
- Reset mid-frame: frame aborted, `tx` returns high asynchronously, FIFO contents discarded.

## Timing
- Reset values: `tx`=1, `data_out`=0x00, `irq`=0, FIFO empty, overflow=0, CTRL=0x00, FSM IDLE.
- Read: `cs && !we` sampled at edge N -> `data_out` valid after edge N, held until the next read; STATUS reflects state before edge N's updates.
- Write: register/FIFO updated at the sampling edge.
- Write DATA at edge N into empty FIFO with FSM IDLE: pop at edge N+1, `tx` falls after edge N+1.
- Frame length exactly 10*CLK_DIV cycles; back-to-back frames contiguous.
- busy asserts at the pop edge, deasserts at the STOP-end edge when FIFO empty.
- `irq` registered: after each edge equals irq_en && empty && !busy.

## Configuration
- `UART_TX_IRQ_EN` defined: CTRL register implemented, `irq` as above.
- Undefined: no CTRL storage, offset 2 reads 0x00 and ignores writes, `irq` tied 0.

## Test plan
- Reset release -> `tx`=1, STATUS read returns 0x04, `irq`=0.
- CLK_DIV=4, write 0xA5 -> `tx` sequence (4 cycles each) 0,1,0,1,0,0,1,0,1,1; busy clears after 40 cycles.
- Write 3 bytes back-to-back -> 30*CLK_DIV cycles of continuous framing, no idle gap; empty reasserts at end.
- Fill FIFO_AW=2 (4 entries) while first frame shifting, write 2 more -> one popped slot accepts the first extra, next sets overflow (STATUS bit3); write STATUS -> bit3 clears; transmitted bytes omit the dropped one.
- Assert `reset` mid-DATA bit -> `tx` high immediately without a clock edge, STATUS 0x04 after release, no resumed frame.
- With `UART_TX_IRQ_EN`: CTRL=0x01, send one byte -> `irq` low during frame, high one cycle after STOP ends; without macro, `irq` stays 0 and CTRL reads 0x00.
